// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ producers, bursts <= BURST_LEN.
// Optional FIFO_WR_ARB_WORDCNT_EN adds a free-running word_cnt output of CNTW bits.
module fifo_wr_arbiter #(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned NREQ      = 4,
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned CNTW      = 16
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  input  logic                  wfull,
  output logic                  busy
`ifdef FIFO_WR_ARB_WORDCNT_EN
  ,
  output logic [CNTW-1:0]       word_cnt
`endif
);

  localparam int unsigned IdxW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BeatW-1:0] BeatMax = BeatW'(BURST_LEN - 1);
  localparam logic [IdxW-1:0]  IdxRst  = IdxW'(NREQ - 1);
  localparam logic [NREQ-1:0]  OneHot0 = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [BeatW-1:0]  beat_q, beat_d;
  logic [IdxW-1:0]   last_idx_q, last_idx_d;

  logic              req_g, last_g, found;
  logic [IdxW-1:0]   win_idx;
  int unsigned       idx;

  // Search upward from last_idx+1 so the previous winner has lowest priority.
  always_comb begin
    win_idx = last_idx_q;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(last_idx_q) + k) % NREQ;
      if (!found && req[IdxW'(idx)]) begin
        found   = 1'b1;
        win_idx = IdxW'(idx);
      end
    end
  end

  // gnt_q is one-hot in XFER and zero in IDLE, so masking selects the granted requester.
  always_comb begin
    req_g  = |(req & gnt_q);
    last_g = |(req_last & gnt_q);
    wdata  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) wdata = wdata | req_data[i*DSIZE +: DSIZE];
    end
    busy = (state_q == StXfer);
    winc = busy & req_g & ~wfull;
    ack  = gnt_q & {NREQ{winc}};
    gnt  = gnt_q;
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    beat_d     = beat_q;
    last_idx_d = last_idx_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d    = StXfer;
          gnt_d      = OneHot0 << win_idx;
          last_idx_d = win_idx;
          beat_d     = '0;
        end
      end
      StXfer: begin
        if (winc) beat_d = beat_q + BeatW'(1);
        if (!req_g || (winc && (last_g || beat_q == BeatMax))) begin
          state_d = StIdle;
          gnt_d   = '0;
          beat_d  = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      beat_q     <= '0;
      last_idx_q <= IdxRst;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      beat_q     <= beat_d;
      last_idx_q <= last_idx_d;
    end
  end

`ifdef FIFO_WR_ARB_WORDCNT_EN
  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst)      cnt_q <= '0;
    else if (winc) cnt_q <= cnt_q + CNTW'(1);
  end

  assign word_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: behavioural producers driven from ack, hand-computed checks.
// Checks word_cnt wrap when FIFO_WR_ARB_WORDCNT_EN is defined.
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst;
  logic [3:0]  req, req_last, gnt, ack;
  logic [31:0] req_data;
  logic        winc, wfull, busy;
  logic [7:0]  wdata;
`ifdef FIFO_WR_ARB_WORDCNT_EN
  logic [3:0]  word_cnt;
`endif

  fifo_wr_arbiter #(
    .DSIZE(8), .NREQ(4), .BURST_LEN(16), .CNTW(4)
  ) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .req_last(req_last),
    .gnt(gnt), .ack(ack), .winc(winc), .wdata(wdata), .wfull(wfull), .busy(busy)
`ifdef FIFO_WR_ARB_WORDCNT_EN
    , .word_cnt(word_cnt)
`endif
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  // Producer model: rem<0 means endless, rem==0 means idle.
  int          rem[4];
  logic [7:0]  pdat[4], pstep[4];
  bit          plast[4];
  bit          full_v;

  logic [3:0]  gnt_s, ack_s;
  logic        winc_s, busy_s;
  logic [7:0]  wdata_s;
  int          bg[8], bw[8], bc[8], bgap[8];

  task automatic apply();
    for (int i = 0; i < 4; i++) begin
      req[i]             = (rem[i] != 0);
      req_last[i]        = plast[i] && (rem[i] == 1);
      req_data[i*8 +: 8] = pdat[i];
    end
    wfull = full_v;
  endtask

  task automatic sample();
    gnt_s = gnt; ack_s = ack; winc_s = winc; busy_s = busy; wdata_s = wdata;
  endtask

  task automatic clk_cycle();
    @(posedge wclk); #1;
    for (int i = 0; i < 4; i++) begin
      if (ack_s[i]) begin
        if (rem[i] > 0) rem[i]--;
        pdat[i] = pdat[i] + pstep[i];
      end
    end
    apply();
    @(negedge wclk);
    sample();
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) begin
      rem[i] = 0; plast[i] = 0; pdat[i] = '0; pstep[i] = 8'd1;
    end
    full_v = 0;
  endtask

  task automatic do_reset();
    idle_all();
    wrst = 1'b1;
    apply();
    @(posedge wclk);
    @(negedge wclk);
    wrst = 1'b0;
    sample();
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Records grant index, words, cycles and preceding idle gap of each completed burst.
  task automatic run_bursts(input int nb, output int got);
    int  done = 0;
    int  idle = 0;
    bit  inb  = 0;
    for (int c = 0; c < 400 && done < nb; c++) begin
      clk_cycle();
      if (gnt_s != 4'b0) begin
        if (!inb) begin
          inb = 1; bg[done] = oh2i(gnt_s); bgap[done] = idle; bw[done] = 0; bc[done] = 0;
        end
        bc[done]++;
        if (winc_s) bw[done]++;
      end else begin
        if (inb) begin inb = 0; done++; idle = 0; end
        idle++;
      end
    end
    got = done;
  endtask

  task automatic test_reset();
    idle_all();
    wrst = 1'b1;
    apply();
    #3;
    sample();
    checks++; if (gnt_s !== 4'b0)  begin errors++; $display("FAIL rst_gnt got %b want 0000", gnt_s); end
    checks++; if (winc_s !== 1'b0) begin errors++; $display("FAIL rst_winc got %b want 0", winc_s); end
    checks++; if (ack_s !== 4'b0)  begin errors++; $display("FAIL rst_ack got %b want 0000", ack_s); end
    checks++; if (wdata_s !== 8'h0) begin errors++; $display("FAIL rst_wdata got %h want 00", wdata_s); end
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy_s); end
    @(posedge wclk);
    @(negedge wclk);
    wrst = 1'b0;
    clk_cycle();
    checks++; if (busy_s !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %b want 0", busy_s); end
  endtask

  task automatic test_single();
    logic [7:0] exp_d[3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    do_reset();
    rem[0] = 3; plast[0] = 1; pdat[0] = 8'h11; pstep[0] = 8'h11;
    clk_cycle();
    checks++; if (gnt_s !== 4'b0) begin errors++; $display("FAIL single_lat got %b want 0000", gnt_s); end
    for (int k = 0; k < 3; k++) begin
      clk_cycle();
      checks++;
      if (gnt_s !== 4'b0001 || winc_s !== 1'b1 || wdata_s !== exp_d[k] || ack_s !== 4'b0001) begin
        errors++;
        $display("FAIL single_word%0d got gnt=%b winc=%b wdata=%h ack=%b want 0001 1 %h 0001",
                 k, gnt_s, winc_s, wdata_s, ack_s, exp_d[k]);
      end
    end
    clk_cycle();
    checks++;
    if (gnt_s !== 4'b0 || busy_s !== 1'b0 || winc_s !== 1'b0) begin
      errors++; $display("FAIL single_end got gnt=%b busy=%b winc=%b want 0000 0 0", gnt_s, busy_s, winc_s);
    end
  endtask

  task automatic test_round_robin();
    int got;
    int exp_g[5];
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 3; exp_g[4] = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin rem[i] = -1; pdat[i] = 8'(i * 16); end
    run_bursts(5, got);
    checks++; if (got !== 5) begin errors++; $display("FAIL rr_timeout got %0d want 5", got); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (bg[k] !== exp_g[k] || bw[k] !== 16 || bc[k] !== 16) begin
        errors++;
        $display("FAIL rr_burst%0d got idx=%0d words=%0d cycles=%0d want %0d 16 16",
                 k, bg[k], bw[k], bc[k], exp_g[k]);
      end
      if (k > 0) begin
        checks++;
        if (bgap[k] !== 1) begin errors++; $display("FAIL rr_gap%0d got %0d want 1", k, bgap[k]); end
      end
    end
    idle_all();
    repeat (3) clk_cycle();
  endtask

  task automatic test_wfull();
    int n = 0;
    do_reset();
    rem[2] = -1; pdat[2] = 8'h20;
    clk_cycle();
    for (int c = 0; c < 20 && n < 7; c++) begin
      clk_cycle();
      if (winc_s) n++;
    end
    checks++; if (n !== 7) begin errors++; $display("FAIL full_pre got %0d want 7", n); end
    full_v = 1;
    for (int c = 0; c < 5; c++) begin
      clk_cycle();
      checks++;
      if (winc_s !== 1'b0 || gnt_s !== 4'b0100) begin
        errors++; $display("FAIL full_hold%0d got winc=%b gnt=%b want 0 0100", c, winc_s, gnt_s);
      end
    end
    full_v = 0;
    clk_cycle();
    checks++;
    if (winc_s !== 1'b1 || wdata_s !== 8'h27) begin
      errors++; $display("FAIL full_resume got winc=%b wdata=%h want 1 27", winc_s, wdata_s);
    end
    n++;
    for (int c = 0; c < 20 && gnt_s != 4'b0; c++) begin
      clk_cycle();
      if (winc_s) n++;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL full_total got %0d want 16", n); end
    idle_all();
    repeat (3) clk_cycle();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    do_reset();
    rem[1] = -1; pdat[1] = 8'h40;
    clk_cycle();
    for (int c = 0; c < 20 && n < 5; c++) begin
      clk_cycle();
      if (winc_s) n++;
    end
    checks++;
    if (n !== 5 || wdata_s !== 8'h44) begin
      errors++; $display("FAIL rmid_pre got n=%0d wdata=%h want 5 44", n, wdata_s);
    end
    wrst = 1'b1;
    #1;
    sample();
    checks++;
    if (gnt_s !== 4'b0 || winc_s !== 1'b0 || ack_s !== 4'b0 || busy_s !== 1'b0 || wdata_s !== 8'h0) begin
      errors++;
      $display("FAIL rmid_async got gnt=%b winc=%b ack=%b busy=%b wdata=%h want 0000 0 0000 0 00",
               gnt_s, winc_s, ack_s, busy_s, wdata_s);
    end
    rem[0] = -1; pdat[0] = 8'h50;
    @(posedge wclk); #1;
    apply();
    @(negedge wclk);
    wrst = 1'b0;
    sample();
    clk_cycle();
    checks++;
    if (gnt_s !== 4'b0001 || wdata_s !== 8'h50) begin
      errors++; $display("FAIL rmid_regrant got gnt=%b wdata=%h want 0001 50", gnt_s, wdata_s);
    end
    idle_all();
    repeat (3) clk_cycle();
  endtask

  task automatic test_withdraw();
    do_reset();
    rem[3] = 2; pdat[3] = 8'hA0;
    clk_cycle();
    clk_cycle();
    checks++;
    if (gnt_s !== 4'b1000 || wdata_s !== 8'hA0) begin
      errors++; $display("FAIL wd_grant got gnt=%b wdata=%h want 1000 a0", gnt_s, wdata_s);
    end
    rem[0] = -1; rem[2] = -1; pdat[2] = 8'h60;
    clk_cycle();
    checks++;
    if (winc_s !== 1'b1 || wdata_s !== 8'hA1) begin
      errors++; $display("FAIL wd_word2 got winc=%b wdata=%h want 1 a1", winc_s, wdata_s);
    end
    clk_cycle();
    checks++;
    if (winc_s !== 1'b0 || gnt_s !== 4'b1000 || busy_s !== 1'b1) begin
      errors++; $display("FAIL wd_drop got winc=%b gnt=%b busy=%b want 0 1000 1", winc_s, gnt_s, busy_s);
    end
    clk_cycle();
    checks++;
    if (gnt_s !== 4'b0 || busy_s !== 1'b0) begin
      errors++; $display("FAIL wd_idle got gnt=%b busy=%b want 0000 0", gnt_s, busy_s);
    end
    clk_cycle();
    checks++; if (gnt_s !== 4'b0001) begin errors++; $display("FAIL wd_next got %b want 0001", gnt_s); end
    idle_all();
    repeat (3) clk_cycle();
  endtask

  task automatic test_last_at_limit();
    int got;
    do_reset();
    rem[0] = 16; plast[0] = 1;
    rem[1] = -1; pdat[1] = 8'h80;
    run_bursts(2, got);
    checks++; if (got !== 2) begin errors++; $display("FAIL lim_timeout got %0d want 2", got); end
    checks++;
    if (bg[0] !== 0 || bw[0] !== 16 || bc[0] !== 16) begin
      errors++; $display("FAIL lim_b0 got idx=%0d words=%0d cycles=%0d want 0 16 16", bg[0], bw[0], bc[0]);
    end
    checks++;
    if (bg[1] !== 1 || bw[1] !== 16 || bgap[1] !== 1) begin
      errors++; $display("FAIL lim_b1 got idx=%0d words=%0d gap=%0d want 1 16 1", bg[1], bw[1], bgap[1]);
    end
    idle_all();
    repeat (3) clk_cycle();
  endtask

  task automatic test_wordcnt();
    int got;
    do_reset();
    rem[0] = 18;
    run_bursts(2, got);
    checks++; if (got !== 2) begin errors++; $display("FAIL wc_timeout got %0d want 2", got); end
    checks++;
    if (bw[0] !== 16 || bw[1] !== 2 || bgap[1] !== 1) begin
      errors++; $display("FAIL wc_trace got %0d %0d gap=%0d want 16 2 1", bw[0], bw[1], bgap[1]);
    end
`ifdef FIFO_WR_ARB_WORDCNT_EN
    checks++; if (word_cnt !== 4'd2) begin errors++; $display("FAIL wc_wrap got %0d want 2", word_cnt); end
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wfull();
    test_reset_mid();
    test_withdraw();
    test_last_at_limit();
    test_wordcnt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the asynchronous FIFO. It shares the single FIFO write port (`winc`/`wdata`/`wfull`) among `NREQ` producers in the write-clock domain, granting each one a burst of up to `BURST_LEN` words. It stalls on `wfull` without losing data or the grant. It sits directly in front of the FIFO write side; the read domain is untouched.

## Interface
- `DSIZE`, 8: data word width; must match the FIFO `DSIZE`.
- `NREQ`, 4: number of requesters, 2..8.
- `BURST_LEN`, 16: maximum words per grant, 1..256.
- `CNTW`, 16: width of the word counter; only used when the macro is enabled.

Ports:
- `wclk`  in  1  write-domain clock.
- `wrst`  in  1  asynchronous, active-high reset.
- `req`  in  NREQ  per-requester request; a requester holds it high while it has a word on its `req_data` slice.
- `req_data`  in  NREQ*DSIZE  packed words; requester i uses bits [i*DSIZE +: DSIZE].
- `req_last`  in  NREQ  marks the current word as the requester's final word; the burst ends after it is accepted.
- `gnt`  out  NREQ  one-hot registered grant, held for the whole burst.
- `ack`  out  NREQ  word from requester i accepted this cycle.
- `winc`  out  1  FIFO write enable.
- `wdata`  out  DSIZE  FIFO write data.
- `wfull`  in  1  FIFO full flag, already synchronised to `wclk`.
- `busy`  out  1  high while in the XFER state.
- `word_cnt`  out  CNTW  total words written; present only with `FIFO_WR_ARB_WORDCNT_EN`.

## Operation
- The FSM has two states, IDLE and XFER. Registered state: `state`, `gnt`, `beat` (counts 0..BURST_LEN-1), and `last_idx` (the index of the last grant).
- **IDLE:**
  - If any `req` bit is set, pick the first set bit searching upward from `last_idx+1`, modulo NREQ.
  - On the next edge: load `gnt` one-hot, set `last_idx` to the winner, clear `beat`, and enter XFER.
  - If no `req` bit is set, stay in IDLE.
- **XFER, with granted index g:**
  - `winc = req[g] & ~wfull`.
  - `wdata = req_data[g]`.
  - `ack = gnt & {NREQ{winc}}`.
  - These outputs are combinational from registered state and inputs.
  - On each `winc`, `beat` increments.
- **Burst end:** the burst ends at the edge where any of the following holds. At that edge `gnt` clears and the FSM returns to IDLE.
  - (a) `winc & req_last[g]`
  - (b) `winc & beat==BURST_LEN-1`
  - (c) `~req[g]`, i.e. the requester withdraws with no write that cycle.
- **`wfull` while in XFER:** `winc` is 0 and the grant and `beat` are held. There is no timeout.
- Outside XFER, `winc`=0, `ack`=0 and `wdata`=0.
- Fairness: after requester i is served, requester i has the lowest priority in the next arbitration.
- `busy` = (state==XFER).

## Timing
- Reset values: `state`=IDLE, `gnt`=0, `beat`=0, `last_idx`=NREQ-1 (so requester 0 wins first), `winc`=0, `ack`=0, `wdata`=0, `busy`=0, `word_cnt`=0.
- Grant latency: `req` rising in IDLE during cycle n gives `gnt` in cycle n+1. The first `winc` is possible in cycle n+1.
- Throughput: 1 word per cycle within a burst. There is exactly 1 IDLE cycle between consecutive bursts.
- `BURST_LEN`=1: every word is its own burst, so the port runs at 1 word per 2 cycles.
- `req_last` and the `BURST_LEN` limit in the same cycle: the burst ends once; no double count.
- Reset asserted mid-burst: all outputs go to their reset values immediately, regardless of the clock. The word in flight that cycle is not written.
- Requesters must not change `req_data[g]` while `req[g]=1` and `ack[g]=0`.

## Configuration
- Macro: `FIFO_WR_ARB_WORDCNT_EN`.
- Defined: the `word_cnt` port exists. It increments by 1 on every `winc`, wraps modulo 2^CNTW, and clears on `wrst`.
- Undefined: there is no `word_cnt` port and no counter logic. All other behaviour is identical.

## Test plan
- Reset, then `req`=4'b0001 with `req_last` on word 3 → `gnt`=0001 one cycle later; exactly 3 `winc` pulses with `wdata` 0x11,0x22,0x33; back to IDLE.
- `req`=4'b1111 held, none asserting `req_last`, `BURST_LEN`=16 → grant order 0,1,2,3,0. Each burst is 16 words, with a 1-cycle gap between bursts.
- `wfull`=1 for 5 cycles mid-burst of requester 2 at `beat`=7 → `winc`=0 and `gnt` is held for those 5 cycles; the burst resumes at `beat`=7 and totals 16 words.
- `wrst` pulsed while requester 1 is at `beat`=4 → `gnt`=0 and `winc`=0 immediately. After release with `req`=4'b0011, requester 0 is granted first.
- Requester 3 drops `req` at `beat`=2 → burst ends after 2 words; the next grant goes to the next set bit above 3, wrapping to 0.
- With `FIFO_WR_ARB_WORDCNT_EN`, `CNTW`=4: 18 total writes → `word_cnt`=2 (wrap). Without the macro, the port is absent and the same stimulus gives the same `winc` trace.
